// File: rtl/mux_7seg_scan.sv
// Multiplexed N-digit 7-segment scan driver: self-timed slot prescaler, per-frame
// data snapshot, hex decode, leading-zero blanking and PWM digit dimming.
module mux_7seg_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SCAN_HZ    = 1000,
  parameter int unsigned PWM_BITS   = 3,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    fpga_clk,
  input  logic                    sys_init_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_int,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic [7:0]              seg,
  output logic                    scan_tick,
  output logic                    frame_done
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW  = 4 * NUM_DIGITS;

  if (DIV < 2) begin : g_div_chk
    $error("mux_7seg_scan: CLK_HZ/SCAN_HZ must be at least 2");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_nd_chk
    $error("mux_7seg_scan: NUM_DIGITS must be in 1..8");
  end

  logic [PW-1:0]         r_presc;
  logic [SW-1:0]         r_sel;
  logic [PWM_BITS-1:0]   r_pwm;
  logic                  r_first;
  logic                  r_live;
  logic [DW-1:0]         r_snap_bcd;
  logic [NUM_DIGITS-1:0] r_snap_dp;
  logic                  r_snap_blz;
  logic                  r_scan_tick;
  logic                  r_frame_done;
  logic [NUM_DIGITS-1:0] r_digit;
  logic [7:0]            r_seg;

  logic [PW-1:0]         w_presc_nxt;
  logic [SW-1:0]         w_sel_nxt;
  logic [PWM_BITS-1:0]   w_pwm_nxt;
  logic                  w_live_nxt;
  logic                  w_cap;
  logic [DW-1:0]         w_bcd_nxt;
  logic [NUM_DIGITS-1:0] w_dp_nxt;
  logic                  w_blz_nxt;
  logic                  w_tick_nxt;
  logic                  w_fd_nxt;
  logic [3:0]            w_nib;
  logic                  w_blank;
  logic                  w_dp;
  logic [6:0]            w_abcdefg;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS-1:0] w_digit_al;
  logic [7:0]            w_seg_al;

  // Slot timing: every output register is loaded from next-state values so the
  // display tracks the slot index in the same cycle the index changes.
  assign w_presc_nxt = (r_presc == PW'(DIV - 1)) ? '0 : r_presc + PW'(1);
  assign w_sel_nxt   = !r_scan_tick ? r_sel :
                       (r_sel == SW'(NUM_DIGITS - 1)) ? '0 : r_sel + SW'(1);
  assign w_pwm_nxt   = r_pwm + PWM_BITS'(1);
  assign w_live_nxt  = r_live | r_scan_tick;
  assign w_tick_nxt  = (w_presc_nxt == PW'(DIV - 1));
  assign w_fd_nxt    = w_tick_nxt && (w_sel_nxt == SW'(NUM_DIGITS - 1));

  // Frame snapshot keeps one coherent value set for a whole frame.
  assign w_cap     = r_first | r_frame_done;
  assign w_bcd_nxt = w_cap ? bcd_int  : r_snap_bcd;
  assign w_dp_nxt  = w_cap ? dp_mask  : r_snap_dp;
  assign w_blz_nxt = w_cap ? blank_lz : r_snap_blz;

  // Segment decode of the selected digit (active-low patterns, 0 = lit).
  always_comb begin
    w_nib     = 4'(w_bcd_nxt >> {w_sel_nxt, 2'b00});
    w_blank   = w_blz_nxt && (w_sel_nxt != '0) &&
                ((w_bcd_nxt >> {w_sel_nxt, 2'b00}) == '0);
    w_dp      = 1'(w_dp_nxt >> w_sel_nxt);
    w_abcdefg = 7'b1111111;
    case (w_nib)
      4'h0: w_abcdefg = 7'b0000001;
      4'h1: w_abcdefg = 7'b1001111;
      4'h2: w_abcdefg = 7'b0010010;
      4'h3: w_abcdefg = 7'b0000110;
      4'h4: w_abcdefg = 7'b1001100;
      4'h5: w_abcdefg = 7'b0100100;
      4'h6: w_abcdefg = 7'b0100000;
      4'h7: w_abcdefg = 7'b0001111;
      4'h8: w_abcdefg = 7'b0000000;
      4'h9: w_abcdefg = 7'b0000100;
      4'hA: w_abcdefg = 7'b0001000;
      4'hB: w_abcdefg = 7'b1100000;
      4'hC: w_abcdefg = 7'b0110001;
      4'hD: w_abcdefg = 7'b1000010;
      4'hE: w_abcdefg = 7'b0110000;
      4'hF: w_abcdefg = 7'b0111000;
      default: w_abcdefg = 7'b1111111;
    endcase
  end

  // Display stays dark until the first slot advance.
  assign w_onehot   = NUM_DIGITS'(1) << w_sel_nxt;
  assign w_digit_al = (w_live_nxt && (w_pwm_nxt <= brightness)) ? ~w_onehot : '1;
  assign w_seg_al   = w_live_nxt ? {(w_blank ? 7'h7F : w_abcdefg), ~w_dp} : 8'hFF;

  always_ff @(posedge fpga_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      r_presc      <= '0;
      r_sel        <= '0;
      r_pwm        <= '0;
      r_first      <= 1'b1;
      r_live       <= 1'b0;
      r_snap_bcd   <= '0;
      r_snap_dp    <= '0;
      r_snap_blz   <= 1'b0;
      r_scan_tick  <= 1'b0;
      r_frame_done <= 1'b0;
      r_digit      <= {NUM_DIGITS{ACTIVE_LOW}};
      r_seg        <= {8{ACTIVE_LOW}};
    end else begin
      r_presc      <= w_presc_nxt;
      r_sel        <= w_sel_nxt;
      r_pwm        <= w_pwm_nxt;
      r_first      <= 1'b0;
      r_live       <= w_live_nxt;
      r_snap_bcd   <= w_bcd_nxt;
      r_snap_dp    <= w_dp_nxt;
      r_snap_blz   <= w_blz_nxt;
      r_scan_tick  <= w_tick_nxt;
      r_frame_done <= w_fd_nxt;
      r_digit      <= ACTIVE_LOW ? w_digit_al : ~w_digit_al;
      r_seg        <= ACTIVE_LOW ? w_seg_al   : ~w_seg_al;
    end
  end

  assign digit      = r_digit;
  assign seg        = r_seg;
  assign scan_tick  = r_scan_tick;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mux_7seg_scan.sv
// Bench for mux_7seg_scan: directed phases plus random stimulus, checked every
// cycle against a cycle-count arithmetic model of the scan.
module tb_mux_7seg_scan;

  localparam int unsigned N      = 4;
  localparam int unsigned CLK_HZ = 40;
  localparam int unsigned SCAN   = 10;
  localparam int unsigned DIV    = CLK_HZ / SCAN;
  localparam int unsigned FRAME  = N * DIV;

  logic        fpga_clk = 1'b0;
  logic        sys_init_n = 1'b0;
  logic [15:0] bcd_int = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic        blank_lz = 1'b0;
  logic [2:0]  brightness = 3'h7;
  logic [3:0]  digit;
  logic [7:0]  seg;
  logic        scan_tick;
  logic        frame_done;

  mux_7seg_scan #(
    .NUM_DIGITS(N), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN), .PWM_BITS(3), .ACTIVE_LOW(1'b1)
  ) dut (
    .fpga_clk(fpga_clk), .sys_init_n(sys_init_n), .bcd_int(bcd_int),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .brightness(brightness),
    .digit(digit), .seg(seg), .scan_tick(scan_tick), .frame_done(frame_done)
  );

  always #5 fpga_clk = ~fpga_clk;

  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [15:0] m_bcd = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic        m_blz = 1'b0;
  logic [2:0]  m_bri = 3'h0;
  logic [6:0]  seg_tbl [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Model clock edge: cycles since release, frame-aligned data capture.
  task automatic edge_update();
    cyc++;
    m_bri = brightness;
    if (cyc == 1 || (cyc % FRAME) == 0) begin
      m_bcd = bcd_int;
      m_dp  = dp_mask;
      m_blz = blank_lz;
    end
  endtask

  task automatic check_outputs();
    int         s;
    logic       blank;
    logic       e_tick;
    logic [3:0] e_dig;
    logic [7:0] e_seg;
    s      = (cyc / DIV) % N;
    e_tick = (cyc % DIV) == DIV - 1;
    if (cyc < DIV) begin
      e_dig = 4'hF;
      e_seg = 8'hFF;
    end else begin
      blank      = m_blz && (s > 0) && ((m_bcd >> (4 * s)) == 16'h0);
      e_seg[7:1] = blank ? 7'h7F : seg_tbl[4'(m_bcd >> (4 * s))];
      e_seg[0]   = ~m_dp[s];
      e_dig      = (3'(cyc % 8) <= m_bri) ? ~(4'b0001 << s) : 4'hF;
    end
    check("digit", 32'(digit), 32'(e_dig));
    check("seg", 32'(seg), 32'(e_seg));
    check("scan_tick", 32'(scan_tick), 32'(e_tick));
    check("frame_done", 32'(frame_done), 32'(e_tick && (s == N - 1)));
  endtask

  task automatic rand_bcd();
    for (int k = 0; k < 4; k++)
      bcd_int[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(posedge fpga_clk);
      edge_update();
      @(negedge fpga_clk);
      check_outputs();
      if (rnd) begin
        if ($urandom_range(0, 15) == 0) rand_bcd();
        if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 31) == 0) brightness = 3'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic check_off(input string tag);
    check({tag, "_digit"}, 32'(digit), 32'hF);
    check({tag, "_seg"}, 32'(seg), 32'hFF);
    check({tag, "_tick"}, 32'(scan_tick), 32'h0);
    check({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    seg_tbl[0]  = 7'b0000001; seg_tbl[1]  = 7'b1001111;
    seg_tbl[2]  = 7'b0010010; seg_tbl[3]  = 7'b0000110;
    seg_tbl[4]  = 7'b1001100; seg_tbl[5]  = 7'b0100100;
    seg_tbl[6]  = 7'b0100000; seg_tbl[7]  = 7'b0001111;
    seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0000100;
    seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b1100000;
    seg_tbl[12] = 7'b0110001; seg_tbl[13] = 7'b1000010;
    seg_tbl[14] = 7'b0110000; seg_tbl[15] = 7'b0111000;

    // Hex digits, DP on digit 1, full brightness.
    bcd_int = 16'h12AF; dp_mask = 4'b0010; blank_lz = 1'b0; brightness = 3'h7;
    repeat (3) @(negedge fpga_clk);
    check_off("reset");
    sys_init_n = 1'b1;
    cyc = 0;
    check_outputs();
    run(3 * FRAME, 1'b0);

    // Leading-zero blanking, then an all-zero value.
    bcd_int = 16'h0007; blank_lz = 1'b1; dp_mask = 4'h0;
    run(3 * FRAME, 1'b0);
    bcd_int = 16'h0000;
    run(2 * FRAME, 1'b0);

    // Dimmest and mid brightness.
    bcd_int = 16'h5A3C; blank_lz = 1'b0; brightness = 3'h0;
    run(2 * FRAME, 1'b0);
    brightness = 3'h3;
    run(2 * FRAME, 1'b0);

    // Mid-frame data change must wait for the next frame.
    bcd_int = 16'h1111; brightness = 3'h7;
    run(2 * FRAME, 1'b0);
    while ((cyc % FRAME) != DIV + 1) run(1, 1'b0);
    bcd_int = 16'h2222;
    run(2 * FRAME, 1'b0);

    // Asynchronous reset in slot 2, then restart from slot 0.
    while (((cyc % FRAME) / DIV) != 2) run(1, 1'b0);
    #1 sys_init_n = 1'b0;
    #1 check_off("rst_async");
    repeat (2) @(negedge fpga_clk);
    check_off("rst_hold");
    bcd_int = 16'h03C5; dp_mask = 4'b1001; blank_lz = 1'b1;
    sys_init_n = 1'b1;
    cyc = 0;
    check_outputs();
    run(2 * FRAME, 1'b0);

    run(2000, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
